sync_fifo_flags: RTL and testbench

//  Single-clock, parametrised-depth FIFO with valid/ready handshakes on both sides.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr_mod.sv | 32 +++
 rtl/sync_fifo_flags.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the flag-rich synchronous FIFO.
package fifo_pkg;

  // Smallest depth for which the pointer/count arithmetic is meaningful.
  localparam int FIFO_MIN_SIZE = 2;

  // Per-cycle occupancy change, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Width of a word count able to represent 0..size inclusive.
  function automatic int fifo_wrds_bits(input int size);
    return $clog2(size + 1);
  endfunction

  // Pointer width for an array of `size` entries; a one-entry array still
  // gets a one-bit pointer so the port never collapses to zero width.
  function automatic int fifo_ptr_bits(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/fifo_ptr_mod.sv
// Modulo-SIZE pointer register with increment enable and synchronous clear.
// SIZE need not be a power of two: the wrap is an explicit compare against
// the last index, never a bit truncation.
module fifo_ptr_mod
  import fifo_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clr,
  input  logic                           i_inc,
  output logic [fifo_ptr_bits(SIZE)-1:0] o_ptr
);

  localparam int             PW   = fifo_ptr_bits(SIZE);
  localparam logic [PW-1:0]  LAST = PW'(SIZE - 1);

  // Pointer advance with wrap at SIZE-1; clear takes priority over increment.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr <= '0;
    end else if (i_clr) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= (o_ptr == LAST) ? '0 : o_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with valid/ready on both sides, arbitrary depth >= 2,
// registered word count and full/almost-full/empty/almost-empty flags,
// synchronous flush and an optional flop-driven output (OUT_REG=1).
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int SIZE         = 4,
  parameter int DAT_BITS     = 8,
  parameter int AFULL_THRESH = SIZE - 1,
  parameter int AEMP_THRESH  = 1,
  parameter int OUT_REG      = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_val,
  input  logic [DAT_BITS-1:0]             i_dat,
  output logic                            o_rdy,
  output logic                            o_full,
  output logic                            o_afull,
  output logic                            o_val,
  output logic [DAT_BITS-1:0]             o_dat,
  input  logic                            i_rdy,
  output logic                            o_emp,
  output logic                            o_aemp,
  output logic [fifo_wrds_bits(SIZE)-1:0] o_wrds
);

  localparam int CW = fifo_wrds_bits(SIZE);
  // With the output register the head word lives in its own flop, so the
  // array only needs to hold the remaining SIZE-1 words.
  localparam int DEPTH = (OUT_REG != 0) ? SIZE - 1 : SIZE;
  localparam int PW    = fifo_ptr_bits(DEPTH);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(SIZE);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] CNT_AEMP  = CW'(AEMP_THRESH);

  // Parameter legality, rejected at elaboration.
  if (SIZE < FIFO_MIN_SIZE) begin : g_bad_size
    $fatal(1, "sync_fifo_flags: SIZE must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > SIZE) begin : g_bad_afull
    $fatal(1, "sync_fifo_flags: AFULL_THRESH must be in 1..SIZE");
  end
  if (AEMP_THRESH < 0 || AEMP_THRESH > SIZE - 1) begin : g_bad_aemp
    $fatal(1, "sync_fifo_flags: AEMP_THRESH must be in 0..SIZE-1");
  end

  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                push;
  logic                pop;
  fifo_op_e            op;
  logic                wr_inc;
  logic                rd_inc;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DAT_BITS-1:0] mem [DEPTH];

  // Handshakes; a flush cycle swallows both sides. o_rdy is a flop, so there
  // is no combinational path from i_rdy to o_rdy, and a full FIFO refuses a
  // push even when a pop happens in the same cycle.
  assign push = i_val & o_rdy & ~i_flush;
  assign pop  = o_val & i_rdy & ~i_flush;
  assign op   = fifo_op_e'({push, pop});

  // Next-state word count: +1, -1 or unchanged; flush forces it to zero.
  // NOTE: assign a default to every always_comb output before any branch so
  // an uncovered path can never infer a latch.
  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else begin
      case (op)
        OP_PUSH: count_d = count_q + CNT_ONE;
        OP_POP:  count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Count and every flag are registered from count_d, so they all change on
  // the same edge as the occupancy itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      o_val   <= 1'b0;
      o_rdy   <= 1'b0;
      o_full  <= 1'b0;
      o_afull <= 1'b0;
      o_emp   <= 1'b1;
      o_aemp  <= 1'b1;
    end else begin
      count_q <= count_d;
      o_val   <= (count_d != '0);
      o_rdy   <= (count_d != CNT_FULL);
      o_full  <= (count_d == CNT_FULL);
      o_afull <= (count_d >= CNT_AFULL);
      o_emp   <= (count_d == '0);
      o_aemp  <= (count_d <= CNT_AEMP);
    end
  end

  assign o_wrds = count_q;

  fifo_ptr_mod #(.SIZE(DEPTH)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (wr_inc),
    .o_ptr   (wr_ptr)
  );

  fifo_ptr_mod #(.SIZE(DEPTH)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (rd_inc),
    .o_ptr   (rd_ptr)
  );

  // Storage array write port.
  // NOTE: the array deliberately has no reset; occupancy is tracked by the
  // count and pointers, so stale words are never observed and the array
  // stays plain flops without a reset tree.
  always_ff @(posedge i_clk) begin
    if (wr_inc) begin
      mem[wr_ptr] <= i_dat;
    end
  end

  if (OUT_REG == 0) begin : g_mux_out
    assign wr_inc = push;
    assign rd_inc = pop;
    // Head word read straight from the array; forced to zero while empty so
    // reset presents a clean bus.
    assign o_dat  = o_val ? mem[rd_ptr] : '0;
  end else begin : g_reg_out
    logic                bypass;
    logic                refill;
    logic [DAT_BITS-1:0] head_q;

    // Head is occupied exactly when count_q != 0, and the array holds the
    // other count_q-1 words. A push goes straight to the head when the array
    // is empty and the head is empty or leaving this cycle.
    assign bypass = push & ((count_q == '0) | ((count_q == CNT_ONE) & pop));
    assign refill = pop & (count_q > CNT_ONE);
    assign wr_inc = push & ~bypass;
    assign rd_inc = refill;

    // Head flop: loaded by bypass or by refill from the array, otherwise it
    // holds (including while empty, keeping the last word visible).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        head_q <= '0;
      end else if (bypass) begin
        head_q <= i_dat;
      end else if (refill) begin
        head_q <= mem[rd_ptr];
      end
    end

    assign o_dat = head_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: DUT A is SIZE=5 with a muxed output, DUT B is SIZE=3 with
// the output register. A is driven from a vector table, B by hand sequences.
module tb_sync_fifo_flags;

  logic clk;
  logic rst_n;

  logic       a_flush, a_ival, a_irdy;
  logic [7:0] a_idat;
  logic       a_ordy, a_full, a_afull, a_oval, a_emp, a_aemp;
  logic [7:0] a_odat;
  logic [2:0] a_wrds;

  logic       b_flush, b_ival, b_irdy;
  logic [7:0] b_idat;
  logic       b_ordy, b_full, b_afull, b_oval, b_emp, b_aemp;
  logic [7:0] b_odat;
  logic [1:0] b_wrds;

  int n_checks = 0;
  int n_err    = 0;

  sync_fifo_flags #(
    .SIZE(5), .DAT_BITS(8), .AFULL_THRESH(4), .AEMP_THRESH(1), .OUT_REG(0)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_val(a_ival),
    .i_dat(a_idat), .o_rdy(a_ordy), .o_full(a_full), .o_afull(a_afull),
    .o_val(a_oval), .o_dat(a_odat), .i_rdy(a_irdy), .o_emp(a_emp),
    .o_aemp(a_aemp), .o_wrds(a_wrds)
  );

  sync_fifo_flags #(
    .SIZE(3), .DAT_BITS(8), .AFULL_THRESH(2), .AEMP_THRESH(1), .OUT_REG(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_val(b_ival),
    .i_dat(b_idat), .o_rdy(b_ordy), .o_full(b_full), .o_afull(b_afull),
    .o_val(b_oval), .o_dat(b_odat), .i_rdy(b_irdy), .o_emp(b_emp),
    .o_aemp(b_aemp), .o_wrds(b_wrds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       val;
    logic [7:0] dat;
    logic       rdy;
    int         exp_wrds;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs [32];
  int   n_vecs;

  function automatic vec_t mk(input logic fl, input logic v, input logic [7:0] d,
                              input logic r, input int w, input logic [7:0] hd);
    vec_t x;
    x.flush = fl; x.val = v; x.dat = d; x.rdy = r; x.exp_wrds = w; x.exp_head = hd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Compares one DUT's outputs with what a given word count implies.
  task automatic check_state(input string tag, input int size, input int af,
                             input int ae, input logic val, input logic full,
                             input logic afull, input logic emp, input logic aemp,
                             input logic rdy, input int wrds, input logic [7:0] dat,
                             input int exp_w, input logic [7:0] exp_d);
    check({tag, " wrds"},  wrds,  exp_w);
    check({tag, " val"},   val,   exp_w != 0);
    check({tag, " full"},  full,  exp_w == size);
    check({tag, " afull"}, afull, exp_w >= af);
    check({tag, " emp"},   emp,   exp_w == 0);
    check({tag, " aemp"},  aemp,  exp_w <= ae);
    check({tag, " rdy"},   rdy,   exp_w != size);
    if (exp_w != 0) check({tag, " dat"}, dat, exp_d);
  endtask

  task automatic a_step(input string tag, input logic fl, input logic v,
                        input logic [7:0] d, input logic r, input int w,
                        input logic [7:0] hd);
    a_flush = fl; a_ival = v; a_idat = d; a_irdy = r;
    @(posedge clk); #1;
    check_state(tag, 5, 4, 1, a_oval, a_full, a_afull, a_emp, a_aemp, a_ordy,
                int'(a_wrds), a_odat, w, hd);
  endtask

  task automatic b_step(input string tag, input logic fl, input logic v,
                        input logic [7:0] d, input logic r, input int w,
                        input logic [7:0] hd);
    b_flush = fl; b_ival = v; b_idat = d; b_irdy = r;
    @(posedge clk); #1;
    check_state(tag, 3, 2, 1, b_oval, b_full, b_afull, b_emp, b_aemp, b_ordy,
                int'(b_wrds), b_odat, w, hd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_ival = 0; a_idat = '0; a_irdy = 0;
    b_flush = 0; b_ival = 0; b_idat = '0; b_irdy = 0;

    // Fill, overflow attempt, pop-only when full, drain, wrap, flush.
    n_vecs = 0;
    vecs[n_vecs++] = mk(0, 1, 8'h10, 0, 1, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h11, 0, 2, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h12, 0, 3, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h13, 0, 4, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h14, 0, 5, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h99, 0, 5, 8'h10);
    vecs[n_vecs++] = mk(0, 1, 8'h77, 1, 4, 8'h11);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 3, 8'h12);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 2, 8'h13);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 1, 8'h14);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 0, 8'h00);
    vecs[n_vecs++] = mk(0, 1, 8'h20, 0, 1, 8'h20);
    vecs[n_vecs++] = mk(0, 1, 8'h21, 0, 2, 8'h20);
    vecs[n_vecs++] = mk(0, 1, 8'h22, 0, 3, 8'h20);
    vecs[n_vecs++] = mk(0, 1, 8'h23, 1, 3, 8'h21);
    vecs[n_vecs++] = mk(0, 1, 8'h24, 1, 3, 8'h22);
    vecs[n_vecs++] = mk(0, 1, 8'h25, 1, 3, 8'h23);
    vecs[n_vecs++] = mk(0, 1, 8'h26, 1, 3, 8'h24);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 2, 8'h25);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 1, 8'h26);
    vecs[n_vecs++] = mk(0, 1, 8'h27, 0, 2, 8'h26);
    vecs[n_vecs++] = mk(0, 1, 8'h28, 0, 3, 8'h26);
    vecs[n_vecs++] = mk(1, 1, 8'h99, 0, 0, 8'h00);
    vecs[n_vecs++] = mk(0, 1, 8'h55, 0, 1, 8'h55);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 0, 1, 8'h55);
    vecs[n_vecs++] = mk(0, 0, 8'h00, 1, 0, 8'h00);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst a_val", a_oval, 0);  check("rst a_rdy", a_ordy, 0);
    check("rst a_emp", a_emp, 1);   check("rst a_aemp", a_aemp, 1);
    check("rst a_full", a_full, 0); check("rst a_afull", a_afull, 0);
    check("rst a_wrds", a_wrds, 0); check("rst a_dat", a_odat, 0);
    check("rst b_val", b_oval, 0);  check("rst b_rdy", b_ordy, 0);
    check("rst b_dat", b_odat, 0);  check("rst b_wrds", b_wrds, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel a_rdy", a_ordy, 1);
    check("rel b_rdy", b_ordy, 1);

    for (int i = 0; i < n_vecs; i++) begin
      a_step($sformatf("A v%0d", i), vecs[i].flush, vecs[i].val, vecs[i].dat,
             vecs[i].rdy, vecs[i].exp_wrds, vecs[i].exp_head);
    end
    a_flush = 0; a_ival = 0; a_irdy = 0;

    // Output-register mode: one-cycle latency from empty, then streaming.
    b_step("B lat", 0, 1, 8'hAA, 0, 1, 8'hAA);
    b_step("B pre", 0, 1, 8'hBB, 0, 2, 8'hAA);
    for (int i = 0; i < 20; i++) begin
      b_step($sformatf("B stream%0d", i), 0, 1, 8'(8'h30 + i), 1, 2,
             (i == 0) ? 8'hBB : 8'(8'h30 + i - 1));
    end
    b_step("B fill",     0, 1, 8'h60, 0, 3, 8'h42);
    b_step("B fullpop",  0, 1, 8'h61, 1, 2, 8'h43);
    b_step("B drain1",   0, 0, 8'h00, 1, 1, 8'h60);
    b_step("B drain0",   0, 0, 8'h00, 1, 0, 8'h00);
    b_step("B f1",       0, 1, 8'h70, 0, 1, 8'h70);
    b_step("B f2",       0, 1, 8'h71, 0, 2, 8'h70);
    b_step("B f3",       0, 1, 8'h72, 0, 3, 8'h70);
    b_step("B flush",    1, 1, 8'h73, 0, 0, 8'h00);
    b_step("B post",     0, 1, 8'h55, 0, 1, 8'h55);
    b_step("B hold",     0, 0, 8'h00, 0, 1, 8'h55);

    // Asynchronous reset between edges while both sides are active.
    a_step("A pre1", 0, 1, 8'h5A, 0, 1, 8'h5A);
    a_step("A pre2", 0, 1, 8'h5B, 0, 2, 8'h5A);
    b_ival = 1; b_idat = 8'h5C; b_irdy = 1;
    a_idat = 8'h5D;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst a_val", a_oval, 0);  check("arst a_rdy", a_ordy, 0);
    check("arst a_wrds", a_wrds, 0); check("arst a_emp", a_emp, 1);
    check("arst b_val", b_oval, 0);  check("arst b_rdy", b_ordy, 0);
    check("arst b_wrds", b_wrds, 0); check("arst b_dat", b_odat, 0);
    a_ival = 0; a_irdy = 0; b_ival = 0; b_irdy = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel2 a_rdy", a_ordy, 1); check("rel2 a_emp", a_emp, 1);
    check("rel2 b_rdy", b_ordy, 1); check("rel2 b_emp", b_emp, 1);
    a_step("A after", 0, 1, 8'h66, 0, 1, 8'h66);
    b_step("B after", 0, 1, 8'h67, 0, 1, 8'h67);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
